// File: rtl/alu_pkg.sv
// Shared opcode encoding and datapath width for the execute-stage ALU.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_MUL = 4'd2,
        ALU_OP_AND = 4'd3,
        ALU_OP_OR  = 4'd4,
        ALU_OP_XOR = 4'd5,
        ALU_OP_NOR = 4'd6,
        ALU_OP_SLL = 4'd7,
        ALU_OP_SRL = 4'd8,
        ALU_OP_ROL = 4'd9,
        ALU_OP_SWP = 4'd10
    } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: produces the result plus carry and overflow.
// Zero/negative/sign are derived from the result by the registered wrapper.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]       ctrl,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] r,
    output logic             c,
    output logic             v
);

    logic [ALU_W:0]       add_sum;
    logic [ALU_W:0]       sub_sum;
    logic signed [31:0]   prod;
    logic                 prod_fits;
    logic                 shift_in_range;
    logic [3:0]           sll_idx;
    logic [3:0]           srl_idx;
    logic [3:0]           rot_amt;
    logic [ALU_W-1:0]     rot;

    // Subtraction reuses the adder form a + ~b + 1 so carry means "no borrow".
    assign add_sum   = {1'b0, a} + {1'b0, b};
    assign sub_sum   = {1'b0, a} + {1'b0, ~b} + 17'd1;
    assign prod      = $signed(a) * $signed(b);
    // The product fits in signed 16 bits when bits 31..15 are all identical.
    assign prod_fits = (prod[31:15] == {17{prod[15]}});

    // Shift carry is only defined for amounts 1..16; index the last bit shifted out.
    assign shift_in_range = (b >= 16'd1) && (b <= 16'd16);
    assign sll_idx        = 4'(5'd16 - b[4:0]);
    assign srl_idx        = 4'(b[4:0] - 5'd1);

    // Rotate uses only the low nibble of b; a right shift by 16 yields zero.
    assign rot_amt = b[3:0];
    assign rot     = (a << rot_amt) | (a >> (5'd16 - {1'b0, rot_amt}));

    // Select the result and carry/overflow for the current opcode.
    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_op_t'(ctrl))
            ALU_OP_ADD: begin
                r = add_sum[ALU_W-1:0];
                c = add_sum[ALU_W];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            ALU_OP_SUB: begin
                r = sub_sum[ALU_W-1:0];
                c = sub_sum[ALU_W];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            ALU_OP_MUL: begin
                r = prod[ALU_W-1:0];
                c = ~prod_fits;
                v = ~prod_fits;
            end
            ALU_OP_AND: r = a & b;
            ALU_OP_OR:  r = a | b;
            ALU_OP_XOR: r = a ^ b;
            ALU_OP_NOR: r = ~(a | b);
            ALU_OP_SLL: begin
                r = (b >= 16'd16) ? '0 : (a << b[3:0]);
                c = shift_in_range ? a[sll_idx] : 1'b0;
            end
            ALU_OP_SRL: begin
                r = (b >= 16'd16) ? '0 : (a >> b[3:0]);
                c = shift_in_range ? a[srl_idx] : 1'b0;
            end
            ALU_OP_ROL: begin
                r = rot;
                c = (rot_amt != 4'd0) ? rot[0] : 1'b0;
            end
            ALU_OP_SWP: r = {a[11:8], a[15:12], a[3:0], a[7:4]};
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_alu.sv
// Registered execute-stage ALU: one cycle from operands to result and flags.
module cpu_alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ctrl,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] y,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             s
);

    logic [ALU_W-1:0] r;
    logic             c_next;
    logic             v_next;
    logic             n_next;

    alu_core u_core (
        .ctrl (ctrl),
        .a    (a),
        .b    (b),
        .r    (r),
        .c    (c_next),
        .v    (v_next)
    );

    assign n_next = r[ALU_W-1];

    // Output register: cleared asynchronously, otherwise loads every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
            c <= 1'b0;
            z <= 1'b0;
            n <= 1'b0;
            v <= 1'b0;
            s <= 1'b0;
        end else begin
            y <= r;
            c <= c_next;
            z <= (r == '0);
            n <= n_next;
            v <= v_next;
            s <= n_next ^ v_next;
        end
    end

endmodule

// File: tb/tb_cpu_alu.sv
// Directed-vector bench for cpu_alu; result and flags compared as {y,c,z,n,v,s}.
module tb_cpu_alu;

    localparam int W = 21;

    logic        clk;
    logic        reset;
    logic [3:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        c, z, n, v, s;

    int          n_checks;
    int          n_fails;
    logic [W-1:0] exp_q[$];

    cpu_alu dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .a     (a),
        .b     (b),
        .y     (y),
        .c     (c),
        .z     (z),
        .n     (n),
        .v     (v),
        .s     (s)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] observed();
        return {y, c, z, n, v, s};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got y=%h cznvs=%b, want y=%h cznvs=%b",
                     tag, obs[20:5], obs[4:0], exp[20:5], exp[4:0]);
        end
    endtask

    // Driver: apply one operation, queue its expectation, check after the edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] ey, input logic [4:0] eflags);
        @(negedge clk);
        ctrl = op;
        a    = va;
        b    = vb;
        exp_q.push_back({ey, eflags});
        @(posedge clk);
        #1;
        check(tag, observed(), exp_q.pop_front());
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        ctrl  = 4'd0;
        a     = 16'h0;
        b     = 16'h0;
        #2;
        check("reset_state", observed(), '0);
        @(negedge clk);
        reset = 1'b0;

        //                            op     a        b        y        cznvs
        run_op("add_ovf",   4'd0,  16'h7fff, 16'h0001, 16'h8000, 5'b00110);
        run_op("add_carry", 4'd0,  16'hffff, 16'h8000, 16'h7fff, 5'b10011);
        run_op("sub_neg",   4'd1,  16'h0003, 16'h0004, 16'hffff, 5'b00101);
        run_op("sub_zero",  4'd1,  16'ha000, 16'ha000, 16'h0000, 5'b11000);
        run_op("mul_ovf",   4'd2,  16'h4000, 16'h4000, 16'h0000, 5'b11011);
        run_op("mul_small", 4'd2,  16'h0003, 16'h0004, 16'h000c, 5'b00000);
        run_op("and",       4'd3,  16'h0ff0, 16'haa55, 16'h0a50, 5'b00000);
        run_op("or",        4'd4,  16'h0ff0, 16'haa55, 16'haff5, 5'b00101);
        run_op("xor",       4'd5,  16'h0ff0, 16'haa55, 16'ha5a5, 5'b00101);
        run_op("nor",       4'd6,  16'h0ff0, 16'haa55, 16'h500a, 5'b00000);
        run_op("sll_8",     4'd7,  16'hf0f0, 16'h0008, 16'hf000, 5'b00101);
        run_op("sll_32",    4'd7,  16'hffff, 16'h0020, 16'h0000, 5'b01000);
        run_op("sll_16",    4'd7,  16'h0001, 16'h0010, 16'h0000, 5'b11000);
        run_op("srl_8",     4'd8,  16'hf0f0, 16'h0008, 16'h00f0, 5'b10000);
        run_op("srl_16",    4'd8,  16'h8000, 16'h0010, 16'h0000, 5'b11000);
        run_op("rol_8",     4'd9,  16'hf0f0, 16'h0008, 16'hf0f0, 5'b00101);
        run_op("rol_hi",    4'd9,  16'hf5fa, 16'h8000, 16'hf5fa, 5'b00101);
        run_op("rol_1",     4'd9,  16'h8001, 16'h0001, 16'h0003, 5'b10000);
        run_op("swp_1234",  4'd10, 16'h1234, 16'h0000, 16'h2143, 5'b00000);
        run_op("swp_8080",  4'd10, 16'h8080, 16'h0000, 16'h0808, 5'b00000);
        run_op("swp_0f0f",  4'd10, 16'h0f0f, 16'h0000, 16'hf0f0, 5'b00101);
        run_op("op_11",     4'd11, 16'hffff, 16'hffff, 16'h0000, 5'b01000);
        run_op("op_15",     4'd15, 16'h1234, 16'h5678, 16'h0000, 5'b01000);

        // Mid-stream reset: clears at once, then holds through an edge.
        run_op("pre_reset", 4'd0,  16'h7fff, 16'h0001, 16'h8000, 5'b00110);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", observed(), '0);
        ctrl = 4'd4;
        a    = 16'hffff;
        b    = 16'hffff;
        @(posedge clk);
        #1;
        check("reset_hold", observed(), '0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_reset", 4'd0, 16'h0003, 16'h0004, 16'h0007, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
